// File: rtl/bit_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer_pkg
// Description : Shared types and helpers for the bit_serializer block.
//               - state_e : two-state controller encoding (IDLE, SHIFT)
//               - clog2   : bit-counter width helper (never returns < 1)
// Revision    : 1.0 - initial release
// ============================================================================
package bit_serializer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Width needed to count 0..value-1. A one-bit counter is the floor so that
  // WIDTH = 1 still has a legal (constant-zero) counter.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer
// Description : Parallel-to-serial stage for the one-bit delay line. Accepts
//               WIDTH-bit words on a valid/ready handshake and emits one bit
//               per enabled cycle, back-to-back words with no bubble.
// Ports       : CLK       - clock, rising edge
//               RST       - synchronous active-high reset
//               inData    - parallel word, sampled on accept
//               inValid   - upstream word available
//               inReady   - block can take a word this cycle
//               outStall  - downstream hold, nothing consumed while high
//               outBit    - serial bit (delay-line data-in)
//               outEnable - outBit consumed this cycle (delay-line write-en)
//               outLast   - final bit of the current word
//               busy      - a word is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] inData,
  input  logic             inValid,
  output logic             inReady,
  input  logic             outStall,
  output logic             outBit,
  output logic             outEnable,
  output logic             outLast,
  output logic             busy
);

  localparam int              CNT_W      = clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;

  logic w_out_enable;
  logic w_last;
  logic w_in_ready;
  logic w_accept;

  // Handshake and emit qualifiers. RST masks both enable and ready so a word
  // in flight is dropped silently and nothing is taken during reset.
  always_comb begin
    w_out_enable = (state_q == SHIFT) && !outStall && !RST;
    w_last       = w_out_enable && (count_q == C_LAST_CNT);
    w_in_ready   = !RST && ((state_q == IDLE) || w_last);
    w_accept     = inValid && w_in_ready;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shreg_d = shreg_q;
    if (w_accept) begin
      // Covers both the idle load and the reload on the final bit, which is
      // what keeps outEnable continuous across words.
      state_d = SHIFT;
      count_d = '0;
      shreg_d = inData;
    end else if (w_out_enable) begin
      shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
      if (w_last) begin
        state_d = IDLE;
        count_d = '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      count_q <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shreg_q <= shreg_d;
    end
  end

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign outBit = shreg_q[WIDTH-1];
    end else begin : g_lsb_first
      assign outBit = shreg_q[0];
    end
  endgenerate

  assign inReady   = w_in_ready;
  assign outEnable = w_out_enable;
  assign outLast   = w_last;
  assign busy      = (state_q == SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_serializer
// Description : Self-checking bench for bit_serializer. Three instances:
//               u_a WIDTH=8 LSB-first, u_b WIDTH=8 MSB-first, u_c WIDTH=1.
//               Expected bits are queued when a word is offered and popped by
//               a per-instance monitor whenever outEnable is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] a_data, b_data;
  logic [0:0] c_data;
  logic a_valid, a_ready, a_stall, a_bit, a_en, a_last, a_busy;
  logic b_valid, b_ready, b_stall, b_bit, b_en, b_last, b_busy;
  logic c_valid, c_ready, c_stall, c_bit, c_en, c_last, c_busy;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_a (
    .CLK(clk), .RST(rst), .inData(a_data), .inValid(a_valid), .inReady(a_ready),
    .outStall(a_stall), .outBit(a_bit), .outEnable(a_en), .outLast(a_last), .busy(a_busy));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_b (
    .CLK(clk), .RST(rst), .inData(b_data), .inValid(b_valid), .inReady(b_ready),
    .outStall(b_stall), .outBit(b_bit), .outEnable(b_en), .outLast(b_last), .busy(b_busy));

  bit_serializer #(.WIDTH(1), .MSB_FIRST(1'b0)) u_c (
    .CLK(clk), .RST(rst), .inData(c_data), .inValid(c_valid), .inReady(c_ready),
    .outStall(c_stall), .outBit(c_bit), .outEnable(c_en), .outLast(c_last), .busy(c_busy));

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int n_cmp    = 0;
  int n_err    = 0;
  int en_cnt_a = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int which, input logic [7:0] w, input int width, input bit msb);
    for (int i = 0; i < width; i++) begin
      exp_t e;
      e.b    = msb ? w[width-1-i] : w[i];
      e.last = (i == width - 1);
      case (which)
        0:       q_a.push_back(e);
        1:       q_b.push_back(e);
        default: q_c.push_back(e);
      endcase
    end
  endtask

  // Bounded wait for inReady while inValid is already asserted.
  task automatic wait_ready(input int which, input string tag);
    logic r;
    r = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      r = (which == 0) ? a_ready : (which == 1) ? b_ready : c_ready;
      if (r === 1'b1) break;
    end
    check(tag, r, 1);
  endtask

  always @(negedge clk) begin
    if (a_en === 1'b1) begin
      en_cnt_a++;
      if (q_a.size() == 0) check("a_unexpected_enable", a_en, 0);
      else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_bit", a_bit, e.b);
        check("a_last", a_last, e.last);
      end
    end
  end

  always @(negedge clk) begin
    if (b_en === 1'b1) begin
      if (q_b.size() == 0) check("b_unexpected_enable", b_en, 0);
      else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_bit", b_bit, e.b);
        check("b_last", b_last, e.last);
      end
    end
  end

  always @(negedge clk) begin
    if (c_en === 1'b1) begin
      if (q_c.size() == 0) check("c_unexpected_enable", c_en, 0);
      else begin
        exp_t e;
        e = q_c.pop_front();
        check("c_bit", c_bit, e.b);
        check("c_last", c_last, e.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] w;
    logic       held;
    int         cnt0;

    rst = 1'b1;
    a_data = '0; a_valid = 1'b0; a_stall = 1'b0;
    b_data = '0; b_valid = 1'b0; b_stall = 1'b0;
    c_data = '0; c_valid = 1'b0; c_stall = 1'b0;

    // ---------------- reset and idle ----------------
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_a_bit", a_bit, 0);
    check("rst_a_last", a_last, 0);
    check("rst_b_bit", b_bit, 0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("idle_a_ready", a_ready, 1);
      check("idle_a_en", a_en, 0);
      check("idle_a_busy", a_busy, 0);
      check("idle_b_ready", b_ready, 1);
      check("idle_c_ready", c_ready, 1);
    end

    // ---------------- single word 8'hA5, LSB first ----------------
    @(posedge clk);
    #1 a_data = 8'hA5; a_valid = 1'b1;
    wait_ready(0, "a5_accept");
    push_word(0, 8'hA5, 8, 1'b0);
    @(posedge clk);
    #1 a_valid = 1'b0; a_data = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("a5_en", a_en, 1);
      check("a5_busy", a_busy, 1);
    end
    @(negedge clk);
    check("a5_done_en", a_en, 0);
    check("a5_done_busy", a_busy, 0);
    check("a5_done_ready", a_ready, 1);

    // ---------------- back-to-back, MSB first ----------------
    @(posedge clk);
    #1 b_data = 8'hF0; b_valid = 1'b1;
    wait_ready(1, "f0_accept");
    push_word(1, 8'hF0, 8, 1'b1);
    @(posedge clk);
    #1 b_data = 8'h0F;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("b2b_en", b_en, 1);
      check("b2b_ready_eq_last", b_ready, b_last);
      if (i == 7) begin
        push_word(1, 8'h0F, 8, 1'b1);
        @(posedge clk);
        #1 b_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_done_en", b_en, 0);
    check("b2b_done_busy", b_busy, 0);

    // ---------------- stall during 8'h3C ----------------
    w = 8'h3C;
    @(posedge clk);
    #1 a_data = w; a_valid = 1'b1;
    wait_ready(0, "3c_accept");
    push_word(0, w, 8, 1'b0);
    cnt0 = en_cnt_a;
    @(posedge clk);
    #1 a_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 a_stall = 1'b1;
    held = a_bit;
    check("stall_pending_bit", held, w[3]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_en", a_en, 0);
      check("stall_bit_held", a_bit, held);
      check("stall_last", a_last, 0);
      check("stall_ready", a_ready, 0);
      check("stall_busy", a_busy, 1);
    end
    @(posedge clk);
    #1 a_stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("resume_en", a_en, 1);
    end
    @(negedge clk);
    check("stall_done_en", a_en, 0);
    check("stall_total_bits", en_cnt_a - cnt0, 8);

    // ---------------- reset mid-word ----------------
    @(posedge clk);
    #1 a_data = 8'hFF; a_valid = 1'b1;
    wait_ready(0, "ff_accept");
    push_word(0, 8'hFF, 8, 1'b0);
    @(posedge clk);
    #1 a_valid = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    q_a.delete();
    @(negedge clk);
    check("midrst_en", a_en, 0);
    check("midrst_ready", a_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("postrst_busy", a_busy, 0);
    check("postrst_en", a_en, 0);
    check("postrst_bit", a_bit, 0);
    @(posedge clk);
    #1 a_data = 8'h01; a_valid = 1'b1;
    wait_ready(0, "01_accept");
    push_word(0, 8'h01, 8, 1'b0);
    @(posedge clk);
    #1 a_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("w01_en", a_en, 1);
    end
    @(negedge clk);
    check("w01_done_en", a_en, 0);

    // ---------------- WIDTH = 1 stream 1,0,1 ----------------
    @(posedge clk);
    #1 c_data = 1'b1; c_valid = 1'b1;
    wait_ready(2, "c_accept");
    push_word(2, 8'h01, 1, 1'b0);
    @(posedge clk);
    #1 c_data = 1'b0;
    @(negedge clk);
    check("c_en_1", c_en, 1);
    check("c_last_eq_en_1", c_last, c_en);
    check("c_ready_1", c_ready, 1);
    push_word(2, 8'h00, 1, 1'b0);
    @(posedge clk);
    #1 c_data = 1'b1;
    @(negedge clk);
    check("c_en_2", c_en, 1);
    check("c_last_eq_en_2", c_last, c_en);
    push_word(2, 8'h01, 1, 1'b0);
    @(posedge clk);
    #1 c_valid = 1'b0;
    @(negedge clk);
    check("c_en_3", c_en, 1);
    check("c_last_eq_en_3", c_last, c_en);
    @(negedge clk);
    check("c_done_en", c_en, 0);
    check("c_done_last", c_last, 0);

    @(negedge clk);
    check("queues_drained", q_a.size() + q_b.size() + q_c.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
